drops_phase_sched: RTL and testbench
====================================

Name: drops_phase_sched

Overview:
- Frame scheduler for the drops game datapath.
- Runs the input, action and display phases in a fixed round-robin order, using a level-enable/done handshake with each phase.
- Adds a per-phase timeout watchdog, a frame counter, and an action-rate divider that sets drop speed. The action phase is skipped on non-divider frames.
- Sits at top level between the pin-facing wrapper and the get_input/action/display blocks. It replaces the inline sequencing FSM.

Parameters:
- TIMEOUT, 200: maximum cycles a phase may wait for done before it is aborted (must be ≥2).
- TO_W, 8: timeout counter width (2^TO_W > TIMEOUT).
- FRAME_W, 16: frame counter width.
- ACT_DIV, 4: action phase runs once every ACT_DIV frames (≥1; 1 means every frame).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_i  in  1  scheduler run request.
- clr_err_i  in  1  clears the sticky timeout flag.
- d_inp_i  in  1  input phase done.
- d_act_i  in  1  action phase done.
- d_disp_i  in  1  display phase done.
- e_inp_o  out  1  input phase enable.
- e_act_o  out  1  action phase enable.
- e_disp_o  out  1  display phase enable.
- phase_o  out  2  current phase: 0 idle, 1 inp, 2 act, 3 disp.
- frame_cnt_o  out  FRAME_W  completed frames.
- timeout_o  out  1  sticky timeout error.
- to_phase_o  out  2  phase code of the most recent timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - All enables 0, phase_o=0, frame_cnt_o=0, timeout_o=0, to_phase_o=0.
  - Divider counter 0, watchdog counter 0.
- States: IDLE, EN_INP, WT_INP, EN_ACT, WT_ACT, EN_DISP, WT_DISP. All outputs are registered.
- Enable timing:
  - e_x_o=1 exactly while state ∈ {EN_x, WT_x}.
  - Each enable rises one cycle after the transition decision and falls the cycle after done or timeout is seen.
  - EN_x always lasts 1 cycle; d_x_i is ignored there because of stale done.
- IDLE: go to EN_INP when run_i=1.
- WT_x exit: leave when d_x_i=1, or when the watchdog reaches TIMEOUT-1 cycles in WT_x.
  - WT_INP exits to EN_ACT if div_cnt==0, else to EN_DISP.
  - WT_ACT exits to EN_DISP.
  - WT_DISP exits to EN_INP if run_i=1, else to IDLE.
- Frame boundary (exit of WT_DISP):
  - frame_cnt_o increments, wrapping modulo 2^FRAME_W.
  - div_cnt increments, wrapping at ACT_DIV-1 to 0.
- run_i sampling: only in IDLE and at the frame boundary. Deasserting run_i mid-frame never truncates the current frame.
- Watchdog:
  - Cleared on entry to every EN state.
  - Increments each WT cycle without done.
  - On expiry: timeout_o←1, to_phase_o←current phase code, then advance as if done.
- Done and expiry in the same cycle: done wins, no error recorded.
- clr_err_i clears timeout_o. If it coincides with a new timeout, set wins.
- phase_o:
  - Tracks the state: inp for EN_INP/WT_INP, act for EN_ACT/WT_ACT, disp for EN_DISP/WT_DISP, 0 for IDLE.
  - Registered alongside the enables, so it is aligned with them.
- Minimum frame latency with an immediate done:
  - Full frame (inp+act+disp): 6 cycles.
  - Skipped-action frame: 4 cycles.
- Reset mid-phase drops all enables asynchronously. The sub-blocks are reset by the same reset.

Decomposition:
- drops_pkg holds:
  - state encoding localparams (3-bit);
  - phase codes PH_IDLE=0, PH_INP=1, PH_ACT=2, PH_DISP=3.
- One sub-module, drops_watchdog: a loadable counter (clear, count, expire) parameterised by TIMEOUT/TO_W.
- The FSM, frame counter and divider stay in drops_phase_sched.

Test Plan:
- Reset, run_i=1, every done returned one cycle after its enable rises, ACT_DIV=1 → enables cycle inp→act→disp, frame_cnt_o=1 after the first full frame (6-cycle minimum), timeout_o=0.
- ACT_DIV=4, 8 frames with run_i=1 → e_act_o pulses only in frames 0 and 4, frame_cnt_o=8, action-skipped frames take 4 cycles minimum.
- d_act_i held 0, TIMEOUT=200 → e_act_o drops after 200 WT cycles, timeout_o=1, to_phase_o=2, display phase follows. clr_err_i pulse → timeout_o=0.
- d_inp_i asserted on exactly the expiry cycle → no timeout, normal advance. Timeout coincident with clr_err_i → timeout_o stays 1.
- run_i dropped during the action phase → frame completes, state goes IDLE, all enables 0, phase_o=0. run_i raised again → EN_INP next cycle.
- rst_n pulsed low during WT_DISP → all outputs 0 immediately. frame_cnt_o preset near 2^FRAME_W-1 → frame_cnt_o wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/drops_pkg.sv
// Shared encodings for the drops frame scheduler: FSM states and phase codes.
package drops_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEnInp  = 3'd1,
    StWtInp  = 3'd2,
    StEnAct  = 3'd3,
    StWtAct  = 3'd4,
    StEnDisp = 3'd5,
    StWtDisp = 3'd6
  } state_e;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INP  = 2'd1;
  localparam logic [1:0] PH_ACT  = 2'd2;
  localparam logic [1:0] PH_DISP = 2'd3;

  // Phase code reported on phase_o for a given scheduler state.
  function automatic logic [1:0] phase_of(input state_e s);
    case (s)
      StEnInp, StWtInp:   phase_of = PH_INP;
      StEnAct, StWtAct:   phase_of = PH_ACT;
      StEnDisp, StWtDisp: phase_of = PH_DISP;
      default:            phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/drops_watchdog.sv
// Per-phase watchdog: cleared on phase entry, counts wait cycles, flags expiry on
// the TIMEOUT-th counted cycle.
module drops_watchdog #(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expire
);

  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  // Only a cycle without done can expire, so a coincident done always wins.
  assign expire = cnt_en && (cnt_q == LastCnt);

endmodule

// File: rtl/drops_phase_sched.sv
// Round-robin frame scheduler: input -> (action every ACT_DIV frames) -> display,
// with per-phase watchdog, frame counter and sticky timeout reporting.
module drops_phase_sched
  import drops_pkg::*;
#(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned ACT_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               clr_err_i,
  input  logic               d_inp_i,
  input  logic               d_act_i,
  input  logic               d_disp_i,
  output logic               e_inp_o,
  output logic               e_act_o,
  output logic               e_disp_o,
  output logic [1:0]         phase_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic               timeout_o,
  output logic [1:0]         to_phase_o
);

  localparam int unsigned DIV_W = (ACT_DIV > 1) ? $clog2(ACT_DIV) : 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(ACT_DIV - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [DIV_W-1:0]   div_q;
  logic               e_inp_q, e_act_q, e_disp_q;
  logic [1:0]         phase_q;
  logic               timeout_q;
  logic [1:0]         to_phase_q;

  logic in_wt, done_cur, wd_clr, wd_cnt_en, wd_expire, frame_end;

  // Select the done line belonging to the phase currently being waited on.
  always_comb begin
    in_wt    = 1'b0;
    done_cur = 1'b0;
    case (state_q)
      StWtInp:  begin in_wt = 1'b1; done_cur = d_inp_i;  end
      StWtAct:  begin in_wt = 1'b1; done_cur = d_act_i;  end
      StWtDisp: begin in_wt = 1'b1; done_cur = d_disp_i; end
      default:  ;
    endcase
  end

  assign wd_cnt_en = in_wt && !done_cur;
  assign wd_clr    = (state_d == StEnInp) || (state_d == StEnAct) || (state_d == StEnDisp);

  drops_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_watchdog (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .cnt_en(wd_cnt_en),
    .expire(wd_expire)
  );

  // Next-state logic; EN states last one cycle so a stale done is never seen.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle:   if (run_i) state_d = StEnInp;
      StEnInp:  state_d = StWtInp;
      StWtInp:  if (d_inp_i || wd_expire) state_d = (div_q == '0) ? StEnAct : StEnDisp;
      StEnAct:  state_d = StWtAct;
      StWtAct:  if (d_act_i || wd_expire) state_d = StEnDisp;
      StEnDisp: state_d = StWtDisp;
      StWtDisp: begin
        if (d_disp_i || wd_expire) begin
          frame_end = 1'b1;
          state_d   = run_i ? StEnInp : StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // State, registered outputs, frame/divider counters and sticky error.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      e_inp_q    <= 1'b0;
      e_act_q    <= 1'b0;
      e_disp_q   <= 1'b0;
      phase_q    <= PH_IDLE;
      frame_q    <= '0;
      div_q      <= '0;
      timeout_q  <= 1'b0;
      to_phase_q <= PH_IDLE;
    end else begin
      state_q  <= state_d;
      e_inp_q  <= (state_d == StEnInp)  || (state_d == StWtInp);
      e_act_q  <= (state_d == StEnAct)  || (state_d == StWtAct);
      e_disp_q <= (state_d == StEnDisp) || (state_d == StWtDisp);
      phase_q  <= phase_of(state_d);
      if (frame_end) begin
        frame_q <= frame_q + FRAME_W'(1);
        div_q   <= (div_q == DivLast) ? '0 : div_q + DIV_W'(1);
      end
      // A new timeout beats a simultaneous clear.
      if (wd_expire) begin
        timeout_q  <= 1'b1;
        to_phase_q <= phase_q;
      end else if (clr_err_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign e_inp_o     = e_inp_q;
  assign e_act_o     = e_act_q;
  assign e_disp_o    = e_disp_q;
  assign phase_o     = phase_q;
  assign frame_cnt_o = frame_q;
  assign timeout_o   = timeout_q;
  assign to_phase_o  = to_phase_q;

endmodule

// File: tb/tb_drops_phase_sched.sv
// Directed bench for drops_phase_sched: instance A uses the default parameters,
// instance B runs the action phase every frame with a 4-bit frame counter.
module tb_drops_phase_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic run_a, clr_a, di_a, da_a, dd_a, ei_a, ea_a, ed_a, to_a;
  logic [1:0]  ph_a, tp_a;
  logic [15:0] fc_a;

  logic run_b, clr_b, di_b, da_b, dd_b, ei_b, ea_b, ed_b, to_b;
  logic [1:0] ph_b, tp_b;
  logic [3:0] fc_b;

  int n_cmp = 0;
  int n_bad = 0;

  drops_phase_sched u_dut_a (
    .clk_i(clk), .rst_n(rst_n), .run_i(run_a), .clr_err_i(clr_a),
    .d_inp_i(di_a), .d_act_i(da_a), .d_disp_i(dd_a),
    .e_inp_o(ei_a), .e_act_o(ea_a), .e_disp_o(ed_a), .phase_o(ph_a),
    .frame_cnt_o(fc_a), .timeout_o(to_a), .to_phase_o(tp_a)
  );

  drops_phase_sched #(
    .TIMEOUT(200), .TO_W(8), .FRAME_W(4), .ACT_DIV(1)
  ) u_dut_b (
    .clk_i(clk), .rst_n(rst_n), .run_i(run_b), .clr_err_i(clr_b),
    .d_inp_i(di_b), .d_act_i(da_b), .d_disp_i(dd_b),
    .e_inp_o(ei_b), .e_act_o(ea_b), .e_disp_o(ed_b), .phase_o(ph_b),
    .frame_cnt_o(fc_b), .timeout_o(to_b), .to_phase_o(tp_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each phase answers done one cycle after its enable rises.
  task automatic step_a();
    di_a = ei_a; da_a = ea_a; dd_a = ed_a;
    tick();
  endtask

  task automatic step_b();
    di_b = ei_b; da_b = ea_b; dd_b = ed_b;
    tick();
  endtask

  task automatic quiet_a();
    di_a = 1'b0; da_a = 1'b0; dd_a = 1'b0;
  endtask

  // Advance A with auto-done until the EN cycle of phase ph.
  task automatic wait_a(input int ph);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ph_a == 2'(ph) && (ei_a || ea_a || ed_a)) begin
        ok = 1'b1;
        break;
      end
      step_a();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_phase_%0d: phase_o=%0d, required phase %0d within 2000 cycles",
               ph, ph_a, ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_a = 0; clr_a = 0; di_a = 0; da_a = 0; dd_a = 0;
    run_b = 0; clr_b = 0; di_b = 0; da_b = 0; dd_b = 0;
    #3;
    n_cmp++;
    if ({ei_a, ea_a, ed_a, ph_a, fc_a, to_a, tp_a} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_a: outputs=%h, required 0",
               {ei_a, ea_a, ed_a, ph_a, fc_a, to_a, tp_a});
    end
    n_cmp++;
    if ({ei_b, ea_b, ed_b, ph_b, fc_b, to_b, tp_b} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_b: outputs=%h, required 0",
               {ei_b, ea_b, ed_b, ph_b, fc_b, to_b, tp_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (ph_a !== 2'd0 || ei_a !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_run: phase_o=%0d e_inp_o=%b, required 0 0", ph_a, ei_a);
    end
  endtask

  // ACT_DIV=1: six-cycle full frame, enables follow phase_o.
  task automatic test_basic();
    logic [1:0] exp_ph [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
    logic [2:0] exp_en;
    run_b = 1'b1;
    step_b();
    for (int k = 0; k < 7; k++) begin
      exp_en = {exp_ph[k] == 2'd1, exp_ph[k] == 2'd2, exp_ph[k] == 2'd3};
      n_cmp++;
      if (ph_b !== exp_ph[k] || {ei_b, ea_b, ed_b} !== exp_en) begin
        n_bad++;
        $display("FAIL basic_seq[%0d]: phase=%0d en=%b, required phase=%0d en=%b",
                 k, ph_b, {ei_b, ea_b, ed_b}, exp_ph[k], exp_en);
      end
      n_cmp++;
      if (fc_b !== ((k == 6) ? 4'd1 : 4'd0)) begin
        n_bad++;
        $display("FAIL basic_frame[%0d]: frame_cnt=%0d, required %0d", k, fc_b, (k == 6));
      end
      if (k < 6) step_b();
    end
    n_cmp++;
    if (to_b !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_timeout: timeout_o=%b, required 0", to_b);
    end
  endtask

  // Frame counter wraps from all-ones to zero.
  task automatic test_wrap();
    int n;
    for (int i = 0; i < 200 && fc_b != 4'hF; i++) step_b();
    n_cmp++;
    if (fc_b !== 4'hF) begin
      n_bad++;
      $display("FAIL wrap_reach: frame_cnt=%h, required F", fc_b);
    end
    n = 0;
    for (int i = 0; i < 20 && fc_b == 4'hF; i++) begin
      step_b();
      n++;
    end
    n_cmp++;
    if (fc_b !== 4'h0 || n != 6) begin
      n_bad++;
      $display("FAIL wrap: frame_cnt=%h after %0d cycles, required 0 after 6", fc_b, n);
    end
    run_b = 1'b0;
    di_b = 0; da_b = 0; dd_b = 0;
  endtask

  // ACT_DIV=4: action only in frames 0 and 4; 8 frames in 36 cycles.
  task automatic test_div();
    logic [7:0] act_frames;
    act_frames = '0;
    run_a = 1'b1;
    step_a();
    for (int k = 0; k < 36; k++) begin
      if (ea_a && fc_a < 16'd8) act_frames[fc_a[2:0]] = 1'b1;
      if (k == 35) begin
        n_cmp++;
        if (fc_a !== 16'd7) begin
          n_bad++;
          $display("FAIL div_frame7: frame_cnt=%0d, required 7", fc_a);
        end
      end
      step_a();
    end
    n_cmp++;
    if (fc_a !== 16'd8 || ph_a !== 2'd1) begin
      n_bad++;
      $display("FAIL div_frame8: frame_cnt=%0d phase=%0d, required 8 1", fc_a, ph_a);
    end
    n_cmp++;
    if (act_frames !== 8'h11) begin
      n_bad++;
      $display("FAIL div_act_frames: mask=%h, required 11", act_frames);
    end
  endtask

  // Action phase never answers: 1 EN + 200 WT cycles, then display follows.
  task automatic test_timeout_act();
    int  n;
    logic early;
    wait_a(2);
    quiet_a();
    n = 1;
    early = to_a;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!ea_a) break;
      n++;
      early |= to_a;
    end
    n_cmp++;
    if (n != 201 || early !== 1'b0) begin
      n_bad++;
      $display("FAIL act_timeout_len: e_act cycles=%0d early_err=%b, required 201 0", n, early);
    end
    n_cmp++;
    if (to_a !== 1'b1 || tp_a !== 2'd2 || ph_a !== 2'd3 || ed_a !== 1'b1) begin
      n_bad++;
      $display("FAIL act_timeout: to=%b to_ph=%0d ph=%0d e_disp=%b, required 1 2 3 1",
               to_a, tp_a, ph_a, ed_a);
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    n_cmp++;
    if (to_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err: timeout_o=%b, required 0", to_a);
    end
  endtask

  // Done on the exact expiry cycle: no error, skip to display (frame 9, div 1).
  task automatic test_done_at_expiry();
    wait_a(1);
    quiet_a();
    for (int i = 0; i < 200; i++) tick();
    n_cmp++;
    if (ei_a !== 1'b1) begin
      n_bad++;
      $display("FAIL expiry_hold: e_inp_o=%b, required 1", ei_a);
    end
    di_a = 1'b1;
    tick();
    di_a = 1'b0;
    n_cmp++;
    if (to_a !== 1'b0 || ei_a !== 1'b0 || ea_a !== 1'b0 || ph_a !== 2'd3) begin
      n_bad++;
      $display("FAIL done_wins: to=%b e_inp=%b e_act=%b ph=%0d, required 0 0 0 3",
               to_a, ei_a, ea_a, ph_a);
    end
  endtask

  // Timeout coincident with clr_err_i: set wins.
  task automatic test_timeout_clr();
    quiet_a();
    for (int i = 0; i < 200; i++) tick();
    n_cmp++;
    if (to_a !== 1'b0 || ed_a !== 1'b1) begin
      n_bad++;
      $display("FAIL disp_hold: to=%b e_disp=%b, required 0 1", to_a, ed_a);
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    n_cmp++;
    if (to_a !== 1'b1 || tp_a !== 2'd3 || ph_a !== 2'd1 || ed_a !== 1'b0 || fc_a !== 16'd10) begin
      n_bad++;
      $display("FAIL set_wins: to=%b to_ph=%0d ph=%0d e_disp=%b frame=%0d, required 1 3 1 0 10",
               to_a, tp_a, ph_a, ed_a, fc_a);
    end
  endtask

  // run_i dropped in the action phase: frame completes, then idle.
  task automatic test_run_drop();
    clr_a = 1'b1;
    step_a();
    clr_a = 1'b0;
    n_cmp++;
    if (to_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err2: timeout_o=%b, required 0", to_a);
    end
    wait_a(2);
    run_a = 1'b0;
    step_a();
    step_a();
    step_a();
    n_cmp++;
    if (ph_a !== 2'd3 || ed_a !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_no_trunc: ph=%0d e_disp=%b, required 3 1", ph_a, ed_a);
    end
    step_a();
    n_cmp++;
    if (ph_a !== 2'd0 || {ei_a, ea_a, ed_a} !== 3'b000 || fc_a !== 16'd13) begin
      n_bad++;
      $display("FAIL drop_idle: ph=%0d en=%b frame=%0d, required 0 000 13",
               ph_a, {ei_a, ea_a, ed_a}, fc_a);
    end
    step_a();
    step_a();
    n_cmp++;
    if (ph_a !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_stay: phase_o=%0d, required 0", ph_a);
    end
    run_a = 1'b1;
    step_a();
    n_cmp++;
    if (ph_a !== 2'd1 || ei_a !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: ph=%0d e_inp=%b, required 1 1", ph_a, ei_a);
    end
  endtask

  // Reset asserted in WT_DISP clears every output without a clock edge.
  task automatic test_reset_mid();
    wait_a(3);
    quiet_a();
    tick();
    n_cmp++;
    if (ed_a !== 1'b1 || fc_a === 16'd0) begin
      n_bad++;
      $display("FAIL pre_reset: e_disp=%b frame=%0d, required 1 nonzero", ed_a, fc_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ei_a, ea_a, ed_a, ph_a, fc_a, to_a, tp_a} !== 24'd0) begin
      n_bad++;
      $display("FAIL async_reset: outputs=%h, required 0",
               {ei_a, ea_a, ed_a, ph_a, fc_a, to_a, tp_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (ph_a !== 2'd1 || fc_a !== 16'd0) begin
      n_bad++;
      $display("FAIL post_reset: ph=%0d frame=%0d, required 1 0", ph_a, fc_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_div();
    test_timeout_act();
    test_done_at_expiry();
    test_timeout_clr();
    test_run_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
